// File: rtl/mac_power_ctrl_if.sv
// mac_power_ctrl_if: mode request handshake and MAC power-control outputs
interface mac_power_ctrl_if;
    logic [2:0] mode_req;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] state_select;
    logic [3:0] supply_en;
    logic       iso_en;
    logic       mac_en;
    logic       busy;
    logic       done;
    logic       err;
    modport master (
        output mode_req, req_valid,
        input  req_ready, state_select, supply_en, iso_en, mac_en, busy, done, err
    );
    modport slave (
        input  mode_req, req_valid,
        output req_ready, state_select, supply_en, iso_en, mac_en, busy, done, err
    );
endinterface

// File: rtl/mac_power_ctrl.sv
// mac_power_ctrl: sequences MAC_UPF power-mode changes (stall, isolate, make-before-break rails, commit, release)
module mac_power_ctrl #(
    parameter int SETTLE_CYCLES = 4
) (
    input logic clk,
    input logic reset,
    mac_power_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DRAIN, ISOLATE, MAKE, BREAK, RELEASE} state_t;
    state_t     st;
    logic [2:0] tgt;
    logic [7:0] cnt;
    logic       last;
    function automatic logic [3:0] rails(input logic [2:0] m);
        return m == 3'b001 ? 4'b0101 :
               m == 3'b011 ? 4'b0110 :
               (m == 3'b010 || m == 3'b110) ? 4'b1001 : 4'b0000;
    endfunction
    function automatic logic legal(input logic [2:0] m);
        return m != 3'b100 && m != 3'b101 && m != 3'b111;
    endfunction
    assign last = cnt == 8'(SETTLE_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            st               <= IDLE;
            tgt              <= 3'b000;
            cnt              <= 8'd0;
            bus.state_select <= 3'b000;
            bus.supply_en    <= 4'b0000;
            bus.iso_en       <= 1'b1;
            bus.mac_en       <= 1'b0;
            bus.req_ready    <= 1'b1;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (st)
                IDLE: if (bus.req_valid && bus.req_ready) begin
                    if (!legal(bus.mode_req)) bus.err <= 1'b1;
                    else if (bus.mode_req != bus.state_select) begin
                        tgt           <= bus.mode_req;
                        st            <= DRAIN;
                        bus.mac_en    <= 1'b0;
                        bus.busy      <= 1'b1;
                        bus.req_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    st         <= ISOLATE;
                    bus.iso_en <= 1'b1;
                end
                ISOLATE: begin
                    st            <= MAKE;
                    cnt           <= 8'd0;
                    bus.supply_en <= bus.supply_en | rails(tgt);
                end
                MAKE: if (last) begin
                    st               <= BREAK;
                    cnt              <= 8'd0;
                    bus.supply_en    <= rails(tgt);
                    bus.state_select <= tgt;
                end else cnt <= cnt + 8'd1;
                BREAK: if (last) begin
                    st         <= RELEASE;
                    bus.iso_en <= tgt == 3'b000;
                end else cnt <= cnt + 8'd1;
                RELEASE: begin
                    st            <= IDLE;
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.req_ready <= 1'b1;
                    bus.mac_en    <= tgt != 3'b000;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_power_ctrl.sv
// tb_mac_power_ctrl: vector table, corner sequences and random requests against a phase-based reference model
module tb_mac_power_ctrl;
    localparam int S = 4;
    localparam int L = 2 * S + 3;
    logic clk = 0;
    logic reset = 1;
    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] m_mode = 3'b000;
    logic [3:0] rt [8] = '{4'b0000, 4'b0101, 4'b1001, 4'b0110, 4'b0000, 4'b0000, 4'b1001, 4'b0000};
    mac_power_ctrl_if bus ();
    mac_power_ctrl #(.SETTLE_CYCLES(S)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [2:0] mode;
        int         hold;
        logic [2:0] exp_sel;
        logic [3:0] exp_sup;
    } vec_t;
    vec_t vecs [9];
    function automatic logic is_legal(input logic [2:0] m);
        return !(m inside {3'b100, 3'b101, 3'b111});
    endfunction
    // {req_ready, state_select, supply_en, iso_en, mac_en, busy, done, err}
    function automatic logic [12:0] idle_v(input logic [2:0] m);
        return {1'b1, m, rt[m], m == 3'b000, m != 3'b000, 3'b000};
    endfunction
    function automatic logic [12:0] exp_at(input logic [2:0] o, input logic [2:0] n, input int k);
        logic bsy, iso, mac;
        logic [3:0] sup;
        logic [2:0] sel;
        bsy = k <= L;
        iso = k == 1 ? o == 3'b000 : k < L ? 1'b1 : n == 3'b000;
        mac = k > L && n != 3'b000;
        sup = k < 3 ? rt[o] : k < 3 + S ? rt[o] | rt[n] : rt[n];
        sel = k < 3 + S ? o : n;
        return {!bsy, sel, sup, iso, mac, bsy, k == L + 1, 1'b0};
    endfunction
    function automatic logic [12:0] act();
        return {bus.req_ready, bus.state_select, bus.supply_en, bus.iso_en, bus.mac_en,
                bus.busy, bus.done, bus.err};
    endfunction
    task automatic chk(input string name, input int k, input logic [12:0] a, input logic [12:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s k=%0d got %b expected %b", name, k, a, e);
        end
    endtask
    task automatic start_req(input logic [2:0] m);
        @(negedge clk);
        bus.mode_req  = m;
        bus.req_valid = 1'b1;
    endtask
    task automatic run(input logic [2:0] m, input int hold, input logic [3:0] nxt, input string name);
        logic [2:0] o;
        logic ill, same;
        int n;
        o    = m_mode;
        ill  = !is_legal(m);
        same = m == o;
        n    = (ill || same) ? 2 : L + 1;
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k > hold) bus.req_valid = 1'b0;
            if (ill) chk(name, k, act(), idle_v(o) | 13'(k == 1));
            else if (same) chk(name, k, act(), idle_v(o));
            else chk(name, k, act(), exp_at(o, m, k));
            if (k == n && nxt[3]) begin
                bus.mode_req  = nxt[2:0];
                bus.req_valid = 1'b1;
            end
        end
        if (!ill) m_mode = m;
    endtask
    task automatic do_req(input logic [2:0] m, input int hold, input string name);
        start_req(m);
        run(m, hold, 4'b0, name);
    endtask
    initial begin
        vecs[0] = '{3'b001, 0, 3'b001, 4'b0101};
        vecs[1] = '{3'b011, 0, 3'b011, 4'b0110};
        vecs[2] = '{3'b010, 0, 3'b010, 4'b1001};
        vecs[3] = '{3'b110, 0, 3'b110, 4'b1001};
        vecs[4] = '{3'b001, 0, 3'b001, 4'b0101};
        vecs[5] = '{3'b101, 0, 3'b001, 4'b0101};
        vecs[6] = '{3'b001, 0, 3'b001, 4'b0101};
        vecs[7] = '{3'b011, 0, 3'b011, 4'b0110};
        vecs[8] = '{3'b000, L, 3'b000, 4'b0000};
        bus.mode_req  = 3'b000;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_vals", 0, act(), 13'b1_000_0000_10000);
        reset = 1'b0;
        foreach (vecs[i]) begin
            do_req(vecs[i].mode, vecs[i].hold, "vec");
            @(negedge clk);
            chk("vec_final", i, {6'b0, bus.state_select, bus.supply_en},
                {6'b0, vecs[i].exp_sel, vecs[i].exp_sup});
        end
        do_req(3'b001, 0, "to_rpm");
        start_req(3'b110);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            chk("pre_rst", k, act(), exp_at(3'b001, 3'b110, k));
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst", 6, act(), idle_v(3'b000));
        reset = 1'b0;
        m_mode = 3'b000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst", k, act(), idle_v(3'b000));
        end
        start_req(3'b001);
        run(3'b001, 0, 4'b1011, "b2b_a");
        run(3'b011, 0, 4'b0, "b2b_b");
        for (int i = 0; i < 25; i++) begin
            do_req(3'($urandom_range(0, 7)), 0, "rand");
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mac_power_ctrl.md
# mac_power_ctrl

Power-mode sequencer for the MAC_UPF datapath. It accepts mode requests over a valid/ready handshake and sequences the change safely. Each change stalls the MAC, isolates it, switches the multiplier and adder supply rails make-before-break, commits `state_select`, and then releases the datapath. It sits between the system power manager and the MAC_UPF instance, driving the MAC's `state_select` and the rail enables for VddMH/VddML/VddAH/VddAL.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 4: rail settle wait in cycles, applied to each of MAKE and BREAK; legal range 1..255.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `mode_req`  in  3: requested mode code.
- `req_valid`  in  1: request present; held stable until accepted.
- `req_ready`  out  1: high only in IDLE; a request is accepted on an edge where `req_valid & req_ready`.
- `state_select`  out  3: committed mode code to MAC_UPF.
- `supply_en`  out  4: rail enables. [3] VddMH, [2] VddML, [1] VddAH, [0] VddAL.
- `iso_en`  out  1: MAC output isolation.
- `mac_en`  out  1: datapath enable or stall for the MAC input stage.
- `busy`  out  1: high in any non-IDLE state.
- `done`  out  1: one-cycle pulse on return to IDLE after a real transition.
- `err`  out  1: one-cycle pulse for an illegal code.

## Operation

- Mode codes and rail sets (`supply_en`):
  - OFF 000 = 0000
  - RPM 001 = 0101
  - LPM 011 = 0110
  - ESM 010 = 1001
  - FPM 110 = 1001
  - Codes 100, 101 and 111 are illegal.
- Reset values:
  - `state_select` = 000, `supply_en` = 0000.
  - `iso_en` = 1, `mac_en` = 0.
  - `req_ready` = 1.
  - `busy`, `done` and `err` = 0.
  - FSM in IDLE with current mode OFF.
- FSM states: IDLE, DRAIN, ISOLATE, MAKE, BREAK, RELEASE.
- **IDLE**:
  - `mac_en` = 1 and `iso_en` = 0 if the current mode is not OFF; otherwise `mac_en` = 0 and `iso_en` = 1.
  - On accept, the target code is latched.
    - Illegal target: `err` pulses and the FSM stays in IDLE with outputs unchanged.
    - Target equals the current mode: no sequence runs, and neither `done` nor `err` pulses.
    - Otherwise: go to DRAIN.
- **DRAIN** (1 cycle): `mac_en` = 0.
- **ISOLATE** (1 cycle): `iso_en` = 1.
- **MAKE** (`SETTLE_CYCLES` cycles): `supply_en` = old set OR new set. `state_select` keeps the old code.
- **BREAK** (`SETTLE_CYCLES` cycles): `supply_en` = new set and `state_select` = new code, both updated on entry.
- **RELEASE** (1 cycle):
  - `iso_en` = 0 unless the target is OFF.
  - Go to IDLE, pulse `done`, and set `mac_en` = 1 in IDLE unless the target is OFF.
- Settle counter: counts 0..`SETTLE_CYCLES`-1 and reloads on entry to MAKE and to BREAK.
- Rails common to the old and new sets never drop during the sequence. Example: ESM to FPM keeps 1001 throughout.
- Reset mid-sequence: outputs return to reset values on the next edge, and the latched target is discarded.

## Timing

- All outputs are registered; no combinational path from inputs to outputs.
- Sequence length: with the accept edge as E0, `busy` is high from E0+1 through E0+(2·`SETTLE_CYCLES`+3). Default: 11 cycles.
- Accept edge E0:
  - `req_ready` = 0 and `busy` = 1 from E0+1.
  - `mac_en` = 0 at E0+1.
  - `iso_en` = 1 at E0+2.
  - MAKE rail union at E0+3.
  - New `state_select`/`supply_en` at E0+3+S.
  - `iso_en` = 0 at E0+3+2S (S = `SETTLE_CYCLES`).
  - `done` = 1, `busy` = 0, `req_ready` = 1 and `mac_en` = 1 at E0+4+2S.
- `err` is high for exactly the cycle after E0; `req_ready` stays high.
- Back-to-back requests: the next accept is possible on the edge ending the `done` cycle.

## Test plan

- Reset, then check all reset values. Request RPM (001) with default S: after 11 cycles `state_select` = 001, `supply_en` = 0101, `iso_en` = 0, `mac_en` = 1, and `done` pulses once.
- RPM to LPM (011): at E0+3 `supply_en` = 0111, at E0+7 `supply_en` = 0110 and `state_select` = 011; VddML never drops.
- ESM (010) to FPM (110): `supply_en` holds 1001 in every cycle, and `state_select` changes at E0+7.
- Request 101 in RPM: `err` pulses 1 cycle, `busy` stays 0, outputs unchanged. Then request 001 again: no `done`, no `busy`.
- LPM to OFF: ends with `supply_en` = 0000, `iso_en` = 1, `mac_en` = 0, `state_select` = 000. Hold `req_valid` high during `busy`: no accept until `req_ready` returns.
- Assert `reset` at E0+5 of an RPM to FPM change: the next edge shows all reset values and IDLE in OFF; `done` never pulses.
